// File: rtl/measure_mc.sv
// measure_mc: multi-channel frequency counter sharing one gate generator.
// Define MEASURE_MC_TIMEOUT_EN to force stalled channels out with a timeout result.
module measure_mc #(
  parameter int CH_NUM     = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int GATE_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [CH_NUM-1:0]      sig_clk_i,
  input  logic                   gate_en_i,
  input  logic [GATE_WIDTH-1:0]  gate_time_i,
  output logic                   reg_wr_en_o,
  output logic [3:0]             reg_wr_addr_o,
  output logic [2*CNT_WIDTH-1:0] reg_wr_data_o,
  output logic                   reg_wr_err_o,
  output logic                   gate_o,
  output logic [CH_NUM-1:0]      gate_sync_o
);

  typedef enum logic [1:0] {G_IDLE, G_OPEN, G_CLOSED} gate_state_t;
  typedef enum logic [1:0] {C_IDLE, C_ARM, C_COUNT, C_DONE} ch_state_t;

  logic [CH_NUM-1:0] sync1_q, sync2_q, prev_q, rise;

  gate_state_t           gst_q, gst_d;
  logic [GATE_WIDTH-1:0] gcnt_q, gcnt_d, gt_load;
`ifdef MEASURE_MC_TIMEOUT_EN
  logic [GATE_WIDTH-1:0] gt_q, gt_d, ccnt_q, ccnt_d;
  logic                  timeout;
  logic [CH_NUM-1:0]     err_q, err_d;
`endif

  ch_state_t            cst_q [CH_NUM];
  ch_state_t            cst_d [CH_NUM];
  logic [CNT_WIDTH-1:0] ref_q [CH_NUM];
  logic [CNT_WIDTH-1:0] ref_d [CH_NUM];
  logic [CNT_WIDTH-1:0] sig_q [CH_NUM];
  logic [CNT_WIDTH-1:0] sig_d [CH_NUM];

  logic       all_idle, open_w, gate_w, wr_hit;
  logic [3:0] wr_idx;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      gst_q   <= G_IDLE;
      gcnt_q  <= '0;
`ifdef MEASURE_MC_TIMEOUT_EN
      gt_q    <= '0;
      ccnt_q  <= '0;
      err_q   <= '0;
`endif
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        cst_q[i] <= C_IDLE;
        ref_q[i] <= '0;
        sig_q[i] <= '0;
      end
    end else begin
      sync1_q <= sig_clk_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      gst_q   <= gst_d;
      gcnt_q  <= gcnt_d;
`ifdef MEASURE_MC_TIMEOUT_EN
      gt_q    <= gt_d;
      ccnt_q  <= ccnt_d;
      err_q   <= err_d;
`endif
      for (int unsigned i = 0; i < CH_NUM; i++) begin
        cst_q[i] <= cst_d[i];
        ref_q[i] <= ref_d[i];
        sig_q[i] <= sig_d[i];
      end
    end
  end

  always_comb begin
    all_idle = 1'b1;
    wr_hit   = 1'b0;
    wr_idx   = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (cst_q[i] != C_IDLE) all_idle = 1'b0;
      if (!wr_hit && cst_q[i] == C_DONE) begin
        wr_hit = 1'b1;
        wr_idx = 4'(i);
      end
    end
    rise   = sync2_q & ~prev_q;
    open_w = (gst_q == G_IDLE) && gate_en_i && all_idle;
    gate_w = (gst_q == G_OPEN);
`ifdef MEASURE_MC_TIMEOUT_EN
    timeout = (gst_q == G_CLOSED) && (ccnt_q >= gt_q);
`endif
  end

  // Gate generator: OPEN lasts exactly the latched length, CLOSED holds until channels drain.
  always_comb begin
    gt_load = (gate_time_i == '0) ? GATE_WIDTH'(1) : gate_time_i;
    gst_d   = gst_q;
    gcnt_d  = gcnt_q;
`ifdef MEASURE_MC_TIMEOUT_EN
    gt_d    = gt_q;
    ccnt_d  = ccnt_q;
`endif
    case (gst_q)
      G_IDLE: if (open_w) begin
        gst_d  = G_OPEN;
        gcnt_d = gt_load - GATE_WIDTH'(1);
`ifdef MEASURE_MC_TIMEOUT_EN
        gt_d   = gt_load;
`endif
      end
      G_OPEN: if (gcnt_q == '0) begin
        gst_d  = G_CLOSED;
`ifdef MEASURE_MC_TIMEOUT_EN
        ccnt_d = '0;
`endif
      end else begin
        gcnt_d = gcnt_q - GATE_WIDTH'(1);
      end
      G_CLOSED: begin
`ifdef MEASURE_MC_TIMEOUT_EN
        if (ccnt_q != '1) ccnt_d = ccnt_q + GATE_WIDTH'(1);
`endif
        if (all_idle) gst_d = G_IDLE;
      end
      default: gst_d = G_IDLE;
    endcase
  end

  always_comb begin
`ifdef MEASURE_MC_TIMEOUT_EN
    err_d = err_q;
`endif
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      cst_d[i] = cst_q[i];
      ref_d[i] = ref_q[i];
      sig_d[i] = sig_q[i];
      case (cst_q[i])
        C_IDLE: if (open_w) cst_d[i] = C_ARM;
        C_ARM: begin
          if (!gate_w) begin
            cst_d[i] = C_IDLE;
          end else if (rise[i]) begin
            cst_d[i] = C_COUNT;
            ref_d[i] = '0;
            sig_d[i] = '0;
`ifdef MEASURE_MC_TIMEOUT_EN
            err_d[i] = 1'b0;
`endif
          end
        end
        C_COUNT: begin
          if (ref_q[i] != '1) ref_d[i] = ref_q[i] + CNT_WIDTH'(1);
          if (rise[i] && sig_q[i] != '1) sig_d[i] = sig_q[i] + CNT_WIDTH'(1);
          if (rise[i] && !gate_w) begin
            cst_d[i] = C_DONE;
`ifdef MEASURE_MC_TIMEOUT_EN
          end else if (timeout) begin
            cst_d[i] = C_DONE;
            ref_d[i] = '1;
            sig_d[i] = '0;
            err_d[i] = 1'b1;
`endif
          end
        end
        C_DONE: if (wr_hit && wr_idx == 4'(i)) cst_d[i] = C_IDLE;
        default: cst_d[i] = C_IDLE;
      endcase
    end
  end

  always_comb begin
    reg_wr_en_o   = wr_hit;
    reg_wr_addr_o = '0;
    reg_wr_data_o = '0;
    reg_wr_err_o  = 1'b0;
    gate_o        = gate_w;
    gate_sync_o   = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      gate_sync_o[i] = (cst_q[i] == C_COUNT);
      if (wr_hit && wr_idx == 4'(i)) begin
        reg_wr_addr_o = wr_idx;
        reg_wr_data_o = {ref_q[i], sig_q[i]};
`ifdef MEASURE_MC_TIMEOUT_EN
        reg_wr_err_o  = err_q[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_measure_mc.sv
// Randomised bench for measure_mc: signal periods are exact in clk cycles, so each
// result is predicted from gate length and period alone.
`timescale 1ns/1ps
module tb_measure_mc;
  localparam int CH = 4;
  localparam int CW = 32;
  localparam int GW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          gate_en = 1'b0;
  logic [GW-1:0] gate_time = '0;
  logic [CH-1:0] sig;

  logic          wr_en, wr_err, gate;
  logic [3:0]    wr_addr;
  logic [2*CW-1:0] wr_data;
  logic [CH-1:0] gsync;
  logic          wr_en8, wr_err8, gate8;
  logic [3:0]    wr_addr8;
  logic [15:0]   wr_data8;
  logic [CH-1:0] gsync8;

  int checks = 0;
  int errors = 0;

  int unsigned per [CH] = '{default: 100};
  int unsigned ph  [CH] = '{default: 0};
  bit          run [CH] = '{default: 1'b0};
  int unsigned cyc = 0;

  int unsigned     w_addr[$];
  logic [2*CW-1:0] w_data[$];
  logic            w_err[$];
  int              w_cyc[$];
  int unsigned     w8_addr[$];
  logic [15:0]     w8_data[$];
  bit              idle_bad;
  int              g_hi;
  int              g_fall;

  measure_mc #(.CH_NUM(CH), .CNT_WIDTH(CW), .GATE_WIDTH(GW)) dut (
    .clk_i(clk), .rst_i(rst), .sig_clk_i(sig), .gate_en_i(gate_en), .gate_time_i(gate_time),
    .reg_wr_en_o(wr_en), .reg_wr_addr_o(wr_addr), .reg_wr_data_o(wr_data),
    .reg_wr_err_o(wr_err), .gate_o(gate), .gate_sync_o(gsync));

  measure_mc #(.CH_NUM(CH), .CNT_WIDTH(8), .GATE_WIDTH(GW)) dut8 (
    .clk_i(clk), .rst_i(rst), .sig_clk_i(sig), .gate_en_i(gate_en), .gate_time_i(gate_time),
    .reg_wr_en_o(wr_en8), .reg_wr_addr_o(wr_addr8), .reg_wr_data_o(wr_data8),
    .reg_wr_err_o(wr_err8), .gate_o(gate8), .gate_sync_o(gsync8));

  always #2.5 clk = ~clk;

  initial begin
    sig = '0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int c = 0; c < CH; c++)
        sig[c] = run[c] && (((cyc + ph[c]) % per[c]) < (per[c] / 2));
    end
  end

  initial begin
    #400us;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  task automatic set_chan(input int c, input int unsigned p, input int unsigned phs, input bit on);
    per[c] = p;
    ph[c]  = phs;
    run[c] = on;
  endtask

  task automatic clear_log();
    w_addr.delete(); w_data.delete(); w_err.delete(); w_cyc.delete();
    w8_addr.delete(); w8_data.delete();
    idle_bad = 1'b0;
    g_hi     = 0;
    g_fall   = -1;
  endtask

  task automatic open_gate(input logic [GW-1:0] g, output bit ok);
    ok        = 1'b0;
    gate_time = g;
    gate_en   = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge clk); #1;
      if (gate === 1'b1) ok = 1'b1;
    end
    gate_en = 1'b0;
    if (ok) g_hi = 1;
  endtask

  task automatic collect(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      if (gate === 1'b1) g_hi++;
      else if (g_fall < 0) g_fall = k;
      if (wr_en === 1'b1) begin
        w_addr.push_back(int'(wr_addr)); w_data.push_back(wr_data);
        w_err.push_back(wr_err); w_cyc.push_back(k);
      end else if (wr_addr !== '0 || wr_data !== '0 || wr_err !== 1'b0) begin
        idle_bad = 1'b1;
      end
      if (wr_en8 === 1'b1) begin
        w8_addr.push_back(int'(wr_addr8)); w8_data.push_back(wr_data8);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    gate_en = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en); end
    checks++; if (wr_addr !== 4'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
    checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL reset_wr_err got %b want 0", wr_err); end
    checks++; if (gate !== 1'b0) begin errors++; $display("FAIL reset_gate got %b want 0", gate); end
    checks++; if (gsync !== '0) begin errors++; $display("FAIL reset_gate_sync got %b want 0", gsync); end
    checks++; if (wr_en8 !== 1'b0) begin errors++; $display("FAIL reset_wr_en8 got %b want 0", wr_en8); end
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_single(input string tag);
    bit ok;
    logic [CW-1:0] r, s;
    logic [7:0] r8, s8;
    set_chan(0, 100, $urandom_range(99, 0), 1'b1);
    for (int c = 1; c < CH; c++) set_chan(c, 100, 0, 1'b0);
    repeat (4) @(negedge clk);
    clear_log();
    open_gate(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_gate_open got 0 want 1", tag); end
    collect(1300);
    checks++; if (idle_bad) begin errors++; $display("FAIL %s_idle_zero got nonzero want 0", tag); end
    checks++;
    if (w_addr.size() != 1) begin
      errors++; $display("FAIL %s_write_count got %0d want 1", tag, w_addr.size());
    end else begin
      s = w_data[0][CW-1:0];
      r = w_data[0][2*CW-1:CW];
      checks++; if (w_addr[0] != 0) begin errors++; $display("FAIL %s_addr got %0d want 0", tag, w_addr[0]); end
      checks++; if (s < 10 || s > 11) begin errors++; $display("FAIL %s_sig got %0d want 10..11", tag, s); end
      checks++; if (r !== 100 * s) begin errors++; $display("FAIL %s_ref got %0d want %0d", tag, r, 100 * s); end
      checks++; if (w_err[0] !== 1'b0) begin errors++; $display("FAIL %s_err got %b want 0", tag, w_err[0]); end
    end
    checks++;
    if (w8_addr.size() != 1) begin
      errors++; $display("FAIL %s_w8_count got %0d want 1", tag, w8_addr.size());
    end else begin
      s8 = w8_data[0][7:0];
      r8 = w8_data[0][15:8];
      checks++; if (r8 !== 8'hFF) begin errors++; $display("FAIL %s_w8_ref_sat got %0d want 255", tag, r8); end
      checks++; if (s8 < 10 || s8 > 11) begin errors++; $display("FAIL %s_w8_sig got %0d want 10..11", tag, s8); end
    end
  endtask

  task automatic test_random();
    bit ok;
    int unsigned g, lo;
    int n, idx;
    logic [CW-1:0] r, s;
    for (int it = 0; it < 5; it++) begin
      g = $urandom_range(1200, 460);
      for (int c = 0; c < CH; c++) set_chan(c, $urandom_range(150, 20), $urandom_range(149, 0), 1'b1);
      repeat (4) @(negedge clk);
      clear_log();
      open_gate(g, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rnd_gate_open it%0d got 0 want 1", it); end
      collect(int'(g) + 400);
      checks++; if (idle_bad) begin errors++; $display("FAIL rnd_idle_zero it%0d got nonzero want 0", it); end
      for (int c = 0; c < CH; c++) begin
        n = 0; idx = 0;
        foreach (w_addr[i]) if (w_addr[i] == c) begin n++; idx = i; end
        checks++;
        if (n != 1) begin
          errors++; $display("FAIL rnd_count it%0d ch%0d got %0d want 1", it, c, n);
        end else begin
          s  = w_data[idx][CW-1:0];
          r  = w_data[idx][2*CW-1:CW];
          lo = g / per[c];
          checks++; if (s < lo || s > lo + 1) begin errors++; $display("FAIL rnd_sig it%0d ch%0d got %0d want %0d..%0d", it, c, s, lo, lo + 1); end
          checks++; if (r !== CW'(per[c]) * s) begin errors++; $display("FAIL rnd_ref it%0d ch%0d got %0d want %0d", it, c, r, CW'(per[c]) * s); end
          checks++; if (w_err[idx] !== 1'b0) begin errors++; $display("FAIL rnd_err it%0d ch%0d got %b want 0", it, c, w_err[idx]); end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int unsigned p;
    logic [CW-1:0] s;
    p = $urandom_range(99, 0);
    for (int c = 0; c < CH; c++) set_chan(c, 100, p, 1'b1);
    repeat (4) @(negedge clk);
    clear_log();
    open_gate(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_gate_open got 0 want 1"); end
    collect(1300);
    checks++;
    if (w_addr.size() != CH) begin
      errors++; $display("FAIL b2b_count got %0d want %0d", w_addr.size(), CH);
    end else begin
      s = w_data[0][CW-1:0];
      checks++; if (s < 10 || s > 11 || w_data[0][2*CW-1:CW] !== 100 * s) begin
        errors++; $display("FAIL b2b_data got %h want sig 10..11 ref 100*sig", w_data[0]); end
      for (int i = 0; i < CH; i++) begin
        checks++; if (w_addr[i] != i) begin errors++; $display("FAIL b2b_addr slot%0d got %0d want %0d", i, w_addr[i], i); end
        checks++; if (w_cyc[i] != w_cyc[0] + i) begin errors++; $display("FAIL b2b_cycle slot%0d got %0d want %0d", i, w_cyc[i], w_cyc[0] + i); end
        checks++; if (w_data[i] !== w_data[0]) begin errors++; $display("FAIL b2b_same_data slot%0d got %h want %h", i, w_data[i], w_data[0]); end
      end
    end
  endtask

  task automatic test_stuck_channel();
    bit ok;
    int n;
    for (int c = 0; c < CH; c++) set_chan(c, 100, $urandom_range(99, 0), c != 2);
    repeat (4) @(negedge clk);
    clear_log();
    open_gate(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stuck_gate_open got 0 want 1"); end
    collect(1300);
    for (int c = 0; c < CH; c++) begin
      n = 0;
      foreach (w_addr[i]) if (w_addr[i] == c) n++;
      checks++; if (n != ((c == 2) ? 0 : 1)) begin
        errors++; $display("FAIL stuck_count ch%0d got %0d want %0d", c, n, (c == 2) ? 0 : 1); end
    end
    clear_log();
    open_gate(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL stuck_next_gate got 0 want 1"); end
    collect(1300);
  endtask

  task automatic test_gate_time();
    bit ok;
    int unsigned g, want;
    for (int c = 0; c < CH; c++) set_chan(c, 100, 0, 1'b0);
    repeat (8) @(negedge clk);
    for (int it = 0; it < 4; it++) begin
      g    = (it == 0) ? 0 : $urandom_range(40, 1);
      want = (g == 0) ? 1 : g;
      clear_log();
      open_gate(g, ok);
      gate_time = g + 9;
      checks++; if (!ok) begin errors++; $display("FAIL glen_open it%0d got 0 want 1", it); end
      collect(int'(want) + 20);
      checks++; if (g_hi != int'(want)) begin errors++; $display("FAIL glen_cycles g=%0d got %0d want %0d", g, g_hi, want); end
      checks++; if (w_addr.size() != 0) begin errors++; $display("FAIL glen_writes got %0d want 0", w_addr.size()); end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    set_chan(0, 100, $urandom_range(99, 0), 1'b1);
    for (int c = 1; c < CH; c++) set_chan(c, 100, 0, 1'b0);
    repeat (4) @(negedge clk);
    clear_log();
    open_gate(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_gate_open got 0 want 1"); end
    collect(500);
    checks++; if (gsync[0] !== 1'b1) begin errors++; $display("FAIL rstmid_counting got %b want 1", gsync[0]); end
    rst = 1'b1;
    @(negedge clk); #1;
    checks++; if (wr_en !== 1'b0 || gate !== 1'b0 || gsync !== '0 || wr_data !== '0) begin
      errors++; $display("FAIL rstmid_outputs got en %b gate %b sync %b want all 0", wr_en, gate, gsync); end
    rst = 1'b0;
    clear_log();
    collect(1200);
    checks++; if (w_addr.size() != 0) begin errors++; $display("FAIL rstmid_no_write got %0d want 0", w_addr.size()); end
    test_single("post_rst");
  endtask

  task automatic stall_channel1(input int unsigned g, output bit ok, output bit seen);
    bit prev;
    for (int c = 0; c < CH; c++) set_chan(c, 100, 0, c == 1);
    repeat (4) @(negedge clk);
    clear_log();
    open_gate(g, ok);
    seen = 1'b0;
    prev = sig[1];
    for (int k = 0; k < 300 && !seen; k++) begin
      @(negedge clk); #1;
      if (sig[1] && !prev) seen = 1'b1;
      prev = sig[1];
    end
    repeat (5) @(negedge clk);
    run[1] = 1'b0;
  endtask

`ifdef MEASURE_MC_TIMEOUT_EN
  task automatic test_timeout();
    bit ok, seen;
    int d;
    stall_channel1(1000, ok, seen);
    checks++; if (!ok || !seen) begin errors++; $display("FAIL tmo_setup got open %b edge %b want 1 1", ok, seen); end
    collect(2300);
    checks++;
    if (w_addr.size() != 1) begin
      errors++; $display("FAIL tmo_count got %0d want 1", w_addr.size());
    end else begin
      d = w_cyc[0] - g_fall;
      checks++; if (w_addr[0] != 1) begin errors++; $display("FAIL tmo_addr got %0d want 1", w_addr[0]); end
      checks++; if (w_err[0] !== 1'b1) begin errors++; $display("FAIL tmo_err got %b want 1", w_err[0]); end
      checks++; if (w_data[0] !== {{CW{1'b1}}, {CW{1'b0}}}) begin errors++; $display("FAIL tmo_data got %h want ones/zero", w_data[0]); end
      checks++; if (g_fall < 0 || d < 1000 || d > 1010) begin errors++; $display("FAIL tmo_delay got %0d want 1000..1010", d); end
    end
  endtask
`else
  task automatic test_no_timeout();
    bit ok, seen;
    stall_channel1(1000, ok, seen);
    checks++; if (!ok || !seen) begin errors++; $display("FAIL notmo_setup got open %b edge %b want 1 1", ok, seen); end
    collect(3000);
    checks++; if (w_addr.size() != 0) begin errors++; $display("FAIL notmo_writes got %0d want 0", w_addr.size()); end
    checks++; if (gsync[1] !== 1'b1 || gate !== 1'b0) begin
      errors++; $display("FAIL notmo_waiting got sync1 %b gate %b want 1 0", gsync[1], gate); end
    rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    checks++; if (gsync !== '0) begin errors++; $display("FAIL notmo_reset_sync got %b want 0", gsync); end
  endtask
`endif

  initial begin
    test_reset();
    test_single("single");
    test_random();
    test_back_to_back();
    test_stuck_channel();
    test_gate_time();
    test_reset_mid();
`ifdef MEASURE_MC_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
